// File: rtl/load_store_unit_if.sv
// Data-memory request/acknowledge bus between the load/store unit (master)
// and data memory (slave).
interface load_store_unit_if #(parameter int ADDR_W = 32);
  logic              dmem_req;
  logic              dmem_we;
  logic [3:0]        dmem_be;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;

  modport master (output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
                  input  dmem_ack, dmem_rdata);
  modport slave  (input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
                  output dmem_ack, dmem_rdata);
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store engine: one outstanding req/ack access,
// byte-enable and lane-replication for stores, lane extract/extend for loads.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_rd,
  output logic              lsu_busy,
  load_store_unit_if.master dmem,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_ldata,
  output logic              lsu_fault
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [4:0]  rd_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        bad_f3, misal, fault_c, go, legal, fault_acc;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_ext;

  always_comb begin
    if (ex_store)
      bad_f3 = ex_funct3[2] || (ex_funct3[1:0] == 2'b11);
    else
      bad_f3 = (ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11);
    case (ex_funct3[1:0])
      2'b01:   misal = ex_addr[0];
      2'b10:   misal = (ex_addr[1:0] != 2'b00);
      default: misal = 1'b0;
    endcase
    // Both load and store set is treated as a malformed request, not ignored.
    fault_c   = (ex_load && ex_store) || bad_f3 || misal;
    go        = (state == IDLE) && ex_valid && (ex_load || ex_store);
    legal     = go && !fault_c;
    fault_acc = go && fault_c;
    lsu_busy  = legal || ((state == BUSY) && !dmem.dmem_ack);
  end

  always_comb begin
    be_n = 4'b1111;
    wd_n = ex_wdata;
    if (ex_store) begin
      case (ex_funct3[1:0])
        2'b00: begin
          be_n = 4'b0001 << ex_addr[1:0];
          wd_n = {4{ex_wdata[7:0]}};
        end
        2'b01: begin
          be_n = ex_addr[1] ? 4'b1100 : 4'b0011;
          wd_n = {2{ex_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Lane select uses the offset latched at accept; rdata is only valid with ack.
  always_comb begin
    byte_sel = dmem.dmem_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   ld_ext = {{24{byte_sel[7] & ~f3_q[2]}}, byte_sel};
      2'b01:   ld_ext = {{16{half_sel[15] & ~f3_q[2]}}, half_sel};
      default: ld_ext = dmem.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      dmem.dmem_req    <= 1'b0;
      dmem.dmem_we     <= 1'b0;
      dmem.dmem_be     <= '0;
      dmem.dmem_addr   <= '0;
      dmem.dmem_wdata  <= '0;
      wb_valid         <= 1'b0;
      wb_rd            <= '0;
      wb_ldata         <= '0;
      lsu_fault        <= 1'b0;
      rd_q             <= '0;
      f3_q             <= '0;
      off_q            <= '0;
    end else begin
      wb_valid  <= 1'b0;
      lsu_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (fault_acc) begin
            lsu_fault <= 1'b1;
          end else if (legal) begin
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= ex_store;
            dmem.dmem_be    <= be_n;
            dmem.dmem_addr  <= {ex_addr[ADDR_W-1:2], 2'b00};
            dmem.dmem_wdata <= wd_n;
            rd_q            <= ex_rd;
            f3_q            <= ex_funct3;
            off_q           <= ex_addr[1:0];
            state           <= BUSY;
          end
        end
        BUSY: begin
          if (dmem.dmem_ack) begin
            dmem.dmem_req <= 1'b0;
            state         <= IDLE;
            if (!dmem.dmem_we) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_q;
              wb_ldata <= ld_ext;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit: table of single accesses plus
// hand sequences for back-to-back, idle ack, and reset mid-access.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_load, ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        lsu_busy, wb_valid, lsu_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_ldata;

  load_store_unit_if #(.ADDR_W(32)) dm();

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .lsu_busy(lsu_busy), .dmem(dm.master),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_ldata(wb_ldata), .lsu_fault(lsu_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          dly;
    logic        flt;
    logic [3:0]  be;
    logic [31:0] mwdata, ldata;
  } vec_t;

  vec_t        vecs[15];
  int          tests = 0, fails = 0;
  logic [31:0] last_ld = '0;
  logic [4:0]  last_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int bc;
    @(negedge clk);
    ex_valid = 1'b1; ex_load = v.ld; ex_store = v.st; ex_funct3 = v.f3;
    ex_addr = v.addr; ex_wdata = v.wdata; ex_rd = 5'(idx + 1);
    #1 chk({v.name, " busy@accept"}, 32'(lsu_busy), 32'(!v.flt));
    @(negedge clk);
    ex_valid = 1'b0;
    if (v.flt) begin
      chk({v.name, " fault"}, 32'(lsu_fault), 1);
      chk({v.name, " no req"}, 32'(dm.dmem_req), 0);
      chk({v.name, " no busy"}, 32'(lsu_busy), 0);
      @(negedge clk);
      chk({v.name, " fault pulse end"}, 32'(lsu_fault), 0);
      chk({v.name, " still no req"}, 32'(dm.dmem_req), 0);
    end else begin
      chk({v.name, " no fault"}, 32'(lsu_fault), 0);
      chk({v.name, " addr"}, dm.dmem_addr, {v.addr[31:2], 2'b00});
      chk({v.name, " we"}, 32'(dm.dmem_we), 32'(v.st));
      chk({v.name, " be"}, 32'(dm.dmem_be), 32'(v.be));
      if (v.st) chk({v.name, " wdata"}, dm.dmem_wdata, v.mwdata);
      bc = 1;
      for (int i = 0; i < v.dly; i++) begin
        chk({v.name, " req held"}, 32'(dm.dmem_req), 1);
        if (lsu_busy) bc++;
        @(negedge clk);
      end
      chk({v.name, " req at ack"}, 32'(dm.dmem_req), 1);
      dm.dmem_ack = 1'b1; dm.dmem_rdata = v.rdata;
      #1 chk({v.name, " busy drops on ack"}, 32'(lsu_busy), 0);
      chk({v.name, " busy cycles"}, 32'(bc), 32'(1 + v.dly));
      @(negedge clk);
      dm.dmem_ack = 1'b0; dm.dmem_rdata = 32'hx;
      chk({v.name, " req dropped"}, 32'(dm.dmem_req), 0);
      chk({v.name, " wb_valid"}, 32'(wb_valid), 32'(v.ld));
      if (v.ld) begin last_ld = v.ldata; last_rd = 5'(idx + 1); end
      chk({v.name, " wb_ldata"}, wb_ldata, last_ld);
      chk({v.name, " wb_rd"}, 32'(wb_rd), 32'(last_rd));
      @(negedge clk);
      chk({v.name, " wb pulse end"}, 32'(wb_valid), 0);
      chk({v.name, " wb_ldata hold"}, wb_ldata, last_ld);
    end
  endtask

  initial begin
    //           name       ld    st    f3     addr          wdata         rdata         dly flt   be       mwdata        ldata
    vecs[0]  = '{"LB",      1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 3, 1'b0, 4'b1111, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{"LHU",     1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 0, 1'b0, 4'b1111, 32'h0,        32'h0000_BEEF};
    vecs[2]  = '{"LH",      1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 0, 1'b0, 4'b1111, 32'h0,        32'hFFFF_BEEF};
    vecs[3]  = '{"LBU",     1'b1, 1'b0, 3'b100, 32'h0000_6001, 32'h0,        32'h1234_C578, 1, 1'b0, 4'b1111, 32'h0,        32'h0000_00C5};
    vecs[4]  = '{"LW",      1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF};
    vecs[5]  = '{"SH_hi",   1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 32'h0,        0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[6]  = '{"SB1",     1'b0, 1'b1, 3'b000, 32'h0000_5001, 32'h0000_005A, 32'h0,        0, 1'b0, 4'b0010, 32'h5A5A_5A5A, 32'h0};
    vecs[7]  = '{"SW",      1'b0, 1'b1, 3'b010, 32'h0000_8004, 32'hCAFE_F00D, 32'h0,        2, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[8]  = '{"SH_lo",   1'b0, 1'b1, 3'b001, 32'h0000_9000, 32'hFFFF_1111, 32'h0,        0, 1'b0, 4'b0011, 32'h1111_1111, 32'h0};
    vecs[9]  = '{"LW_mis",  1'b1, 1'b0, 3'b010, 32'h0000_4001, 32'h0,        32'h0,        0, 1'b1, 4'b0,    32'h0,        32'h0};
    vecs[10] = '{"LD_f011", 1'b1, 1'b0, 3'b011, 32'h0000_4000, 32'h0,        32'h0,        0, 1'b1, 4'b0,    32'h0,        32'h0};
    vecs[11] = '{"LH_mis",  1'b1, 1'b0, 3'b001, 32'h0000_4003, 32'h0,        32'h0,        0, 1'b1, 4'b0,    32'h0,        32'h0};
    vecs[12] = '{"ST_f011", 1'b0, 1'b1, 3'b011, 32'h0000_4000, 32'h0,        32'h0,        0, 1'b1, 4'b0,    32'h0,        32'h0};
    vecs[13] = '{"LD_ST",   1'b1, 1'b1, 3'b010, 32'h0000_4000, 32'h0,        32'h0,        0, 1'b1, 4'b0,    32'h0,        32'h0};
    vecs[14] = '{"SB3",     1'b0, 1'b1, 3'b000, 32'h0000_5003, 32'h0000_00A7, 32'h0,        1, 1'b0, 4'b1000, 32'hA7A7_A7A7, 32'h0};

    rst = 1'b1; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = '0;
    ex_addr = '0; ex_wdata = '0; ex_rd = '0; dm.dmem_ack = 1'b0; dm.dmem_rdata = '0;
    #12;
    chk("rst req", 32'(dm.dmem_req), 0);
    chk("rst be", 32'(dm.dmem_be), 0);
    chk("rst addr", dm.dmem_addr, 0);
    chk("rst wdata", dm.dmem_wdata, 0);
    chk("rst wb", {26'(wb_rd), wb_valid, lsu_fault, dm.dmem_we, 1'b0}, 0);
    chk("rst ldata", wb_ldata, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // No action without ex_valid, and ack while idle is ignored.
    @(negedge clk);
    ex_valid = 1'b0; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h100;
    dm.dmem_ack = 1'b1; dm.dmem_rdata = 32'h1111_2222;
    #1 chk("idle busy", 32'(lsu_busy), 0);
    @(negedge clk);
    chk("idle req", 32'(dm.dmem_req), 0);
    chk("idle wb_valid", 32'(wb_valid), 0);
    ex_valid = 1'b1; ex_load = 1'b0;
    @(negedge clk);
    chk("no ld/st req", 32'(dm.dmem_req), 0);
    chk("no ld/st fault", 32'(lsu_fault), 0);
    chk("idle ack ldata", wb_ldata, last_ld);
    ex_valid = 1'b0; dm.dmem_ack = 1'b0;

    // Back-to-back: SB then LW; second req after one idle accept cycle.
    @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b1; ex_funct3 = 3'b000;
    ex_addr = 32'h5001; ex_wdata = 32'h5A; ex_rd = 5'd3;
    @(negedge clk);
    chk("b2b sb be", 32'(dm.dmem_be), 32'h2);
    chk("b2b sb wdata", dm.dmem_wdata, 32'h5A5A_5A5A);
    dm.dmem_ack = 1'b1;
    ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h5000; ex_rd = 5'd9;
    @(negedge clk);
    dm.dmem_ack = 1'b0;
    chk("b2b gap req", 32'(dm.dmem_req), 0);
    chk("b2b accept busy", 32'(lsu_busy), 1);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("b2b lw req", 32'(dm.dmem_req), 1);
    chk("b2b lw addr", dm.dmem_addr, 32'h5000);
    chk("b2b lw we", 32'(dm.dmem_we), 0);
    dm.dmem_ack = 1'b1; dm.dmem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    dm.dmem_ack = 1'b0;
    chk("b2b lw wb_valid", 32'(wb_valid), 1);
    chk("b2b lw ldata", wb_ldata, 32'h0BAD_F00D);
    chk("b2b lw rd", 32'(wb_rd), 9);

    // Reset while BUSY aborts the access asynchronously.
    @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'hA000; ex_rd = 5'd7;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("mid req", 32'(dm.dmem_req), 1);
    #2 rst = 1'b1;
    #1 chk("async req drop", 32'(dm.dmem_req), 0);
    chk("async ldata clr", wb_ldata, 0);
    @(negedge clk); rst = 1'b0;
    dm.dmem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post-rst wb_valid", 32'(wb_valid), 0);
      chk("post-rst busy", 32'(lsu_busy), 0);
    end
    dm.dmem_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
